// File: rtl/ha_array_reducer.sv
// ---------------------------------------------------------------------------
// ha_array_reducer
//
// Consumer end of the 8x8 approximate-multiplier HA-array interface. Accepts
// one operand set (four half-adder-array rows, each a t/sum vector and a
// b/carry vector) over a valid/ready handshake. It then folds the captured
// rows into an accumulator, one row per clock, and presents the unsigned
// product on a valid/ready output.
//
// Row value : row_k = sum(t[i] * 2^i) + sum(b[i] * 2^(i+2))
// Product   : p     = sum(row_k * 2^(2k))
//
// Ports
//   clk            in   1    clock, rising edge
//   rst_n          in   1    asynchronous active-low reset
//   in_valid       in   1    operand set present
//   in_ready       out  1    operand set can be accepted this cycle
//   ha_array_k_b   in   BW   row k carries (k = 0..3)
//   ha_array_k_t   in   TW   row k sums    (k = 0..3)
//   out_valid      out  1    product valid
//   out_ready      in   1    downstream accepts the product
//   p              out  PW   reduced product
//   busy           out  1    high while rows are being accumulated
//
// Timing
//   The accept edge is followed by ROWS accumulate edges. out_valid rises
//   after the last of them, so one result is produced every ROWS+1 cycles.
//   In DONE, in_ready follows out_ready. A new set can therefore be taken on
//   the same edge that the current product is consumed, with no idle bubble.
//
// The port list is fixed at four rows. ROWS is kept as a parameter so that
// the counter and capture arrays are sized from one place.
// ---------------------------------------------------------------------------
module ha_array_reducer #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned TW   = 9,
    parameter int unsigned BW   = 7,
    parameter int unsigned PW   = 17
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] ha_array_0_b,
    input  logic [TW-1:0] ha_array_0_t,
    input  logic [BW-1:0] ha_array_1_b,
    input  logic [TW-1:0] ha_array_1_t,
    input  logic [BW-1:0] ha_array_2_b,
    input  logic [TW-1:0] ha_array_2_t,
    input  logic [BW-1:0] ha_array_3_b,
    input  logic [TW-1:0] ha_array_3_t,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] p,
    output logic          busy
);

    localparam int unsigned CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_e        r_state;
    state_e        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] w_acc_next;
    logic [PW-1:0] r_p;
    logic [PW-1:0] w_p_next;

    logic [TW-1:0] r_t [ROWS];
    logic [BW-1:0] r_b [ROWS];

    // Gather the flat row ports into arrays so capture is a simple loop.
    logic [TW-1:0] w_in_t [ROWS];
    logic [BW-1:0] w_in_b [ROWS];

    assign w_in_t[0] = ha_array_0_t;
    assign w_in_t[1] = ha_array_1_t;
    assign w_in_t[2] = ha_array_2_t;
    assign w_in_t[3] = ha_array_3_t;
    assign w_in_b[0] = ha_array_0_b;
    assign w_in_b[1] = ha_array_1_b;
    assign w_in_b[2] = ha_array_2_b;
    assign w_in_b[3] = ha_array_3_b;

    // -----------------------------------------------------------------------
    // Row reduction datapath
    // -----------------------------------------------------------------------
    logic          w_accept;
    logic          w_last_row;
    logic [TW-1:0] w_sel_t;
    logic [BW-1:0] w_sel_b;
    logic [PW-1:0] w_row_val;
    logic [PW-1:0] w_row_shifted;
    logic [PW-1:0] w_sum;

    assign w_sel_t = r_t[r_cnt];
    assign w_sel_b = r_b[r_cnt];

    // Carries sit two bit positions above the sums of the same row.
    assign w_row_val     = PW'(w_sel_t) + (PW'(w_sel_b) << 2);
    // Row k has base weight 4^k.
    assign w_row_shifted = w_row_val << {r_cnt, 1'b0};
    assign w_sum         = r_acc + w_row_shifted;
    assign w_last_row    = (r_cnt == CW'(ROWS - 1));

    assign w_accept  = in_valid & in_ready;

    assign out_valid = (r_state == StDone);
    assign busy      = (r_state == StAccum);
    assign p         = r_p;

    // -----------------------------------------------------------------------
    // FSM: next state, counter/accumulator updates and in_ready
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_acc_next   = r_acc;
        w_p_next     = r_p;
        in_ready     = 1'b0;

        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = StAccum;
                    w_cnt_next   = '0;
                    w_acc_next   = '0;
                end
            end

            StAccum: begin
                w_acc_next = w_sum;
                w_cnt_next = r_cnt + CW'(1);
                if (w_last_row) begin
                    w_p_next     = w_sum;
                    w_cnt_next   = '0;
                    w_state_next = StDone;
                end
            end

            StDone: begin
                // Taking a new set is only allowed on the edge that frees the
                // output, so the held product can never be overwritten.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_next = StAccum;
                        w_cnt_next   = '0;
                        w_acc_next   = '0;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_p     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_acc   <= w_acc_next;
            r_p     <= w_p_next;
        end
    end

    // -----------------------------------------------------------------------
    // Operand capture: inputs are don't-care after the accept edge
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(ROWS); k++) begin
                r_t[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < int'(ROWS); k++) begin
                r_t[k] <= w_in_t[k];
                r_b[k] <= w_in_b[k];
            end
        end
    end

endmodule

// File: tb/tb_ha_array_reducer.sv
module tb_ha_array_reducer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] p;
    logic        busy;
    logic [8:0]  tv [4];
    logic [6:0]  bv [4];

    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_pop  = 0;
    logic [16:0] sb_q [$];

    ha_array_reducer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (bv[0]),
        .ha_array_0_t (tv[0]),
        .ha_array_1_b (bv[1]),
        .ha_array_1_t (tv[1]),
        .ha_array_2_b (bv[2]),
        .ha_array_2_t (tv[2]),
        .ha_array_3_b (bv[3]),
        .ha_array_3_t (tv[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .p            (p),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit-by-bit weighted sum over every row.
    function automatic logic [16:0] ref_p();
        int unsigned s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++) if (tv[k][i]) s += (32'd1 << (i + 2 * k));
            for (int i = 0; i < 7; i++) if (bv[k][i]) s += (32'd1 << (i + 2 + 2 * k));
        end
        return s[16:0];
    endfunction

    // Scoreboard: inputs settle at posedge+1, so the negedge view matches what
    // the next rising edge will see. Pop before push keeps ordering correct on
    // back-to-back edges.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (out_valid && busy) begin
                errors++;
                $display("FAIL valid_in_accum: out_valid=%0b busy=%0b required busy=0", out_valid,
                         busy);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: product %0d emitted, required none", p);
                end else begin
                    logic [16:0] exp_p;
                    exp_p = sb_q.pop_front();
                    n_pop++;
                    if (p !== exp_p) begin
                        errors++;
                        $display("FAIL sb_product: p=%0d required %0d", p, exp_p);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_p());
                n_push++;
            end
        end
    end

    task automatic clear_inputs();
        for (int k = 0; k < 4; k++) begin
            tv[k] = '0;
            bv[k] = '0;
        end
    endtask

    // Raise in_valid and hold until accepted; returns at accept edge + 1.
    task automatic send();
        int n;
        n = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_valid_timeout: out_valid=%0b, required 1", out_valid);
        end
    endtask

    task automatic run_one(input string name, input logic [16:0] exp_p);
        send();
        wait_valid();
        checks++;
        if (p !== exp_p) begin
            errors++;
            $display("FAIL %s: p=%0d required %0d", name, p, exp_p);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: out_valid=%0b required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 17'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b p=%0d busy=%0b required 1 0 0 0",
                     in_ready, out_valid, p, busy);
        end
    endtask

    task automatic test_single_bit();
        clear_inputs();
        tv[0] = 9'h001;
        send();
        clear_inputs();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_accum_c%0d: busy=%0b out_valid=%0b in_ready=%0b required 1 0 0",
                         c, busy, out_valid, in_ready);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || p !== 17'd1) begin
            errors++;
            $display("FAIL single_latency: busy=%0b out_valid=%0b p=%0d required 0 1 1", busy,
                     out_valid, p);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || p !== 17'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_after_hs: out_valid=%0b p=%0d in_ready=%0b required 0 1 1",
                     out_valid, p, in_ready);
        end
    endtask

    task automatic test_carry_only();
        clear_inputs();
        for (int k = 0; k < 4; k++) bv[k] = 7'h40;
        run_one("carry_only", 17'd21760);
    endtask

    task automatic test_all_ones();
        for (int k = 0; k < 4; k++) begin
            tv[k] = 9'h1FF;
            bv[k] = 7'h7F;
        end
        run_one("all_ones", 17'd86615);
    endtask

    task automatic test_back_to_back();
        logic [16:0] pa;
        clear_inputs();
        tv[0] = 9'h0AA;
        bv[1] = 7'h15;
        tv[2] = 9'h133;
        bv[3] = 7'h09;
        pa = ref_p();
        send();
        wait_valid();
        clear_inputs();
        tv[3] = 9'h100;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (p !== pa || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_c%0d: p=%0d in_ready=%0b out_valid=%0b required %0d 0 1", c, p,
                         in_ready, out_valid, pa);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_inputs();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_edge: busy=%0b out_valid=%0b required 1 0", busy, out_valid);
        end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_early_c%0d: out_valid=%0b required 0", c, out_valid);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || p !== 17'd16384) begin
            errors++;
            $display("FAIL b2b_result: out_valid=%0b p=%0d required 1 16384", out_valid, p);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        tv[1] = 9'h0F0;
        bv[2] = 7'h33;
        send();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || p !== 17'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%0b p=%0d in_ready=%0b busy=%0b required 0 0 1 0",
                     out_valid, p, in_ready, busy);
        end
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_stale_c%0d: out_valid=%0b in_ready=%0b required 0 1", c,
                         out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int  push0;
        int  pop0;
        int  n;
        bit  drv_done;
        push0    = n_push;
        pop0     = n_pop;
        drv_done = 1'b0;
        fork
            begin
                for (int s = 0; s < 40; s++) begin
                    for (int k = 0; k < 4; k++) begin
                        tv[k] = (s == 0) ? 9'd0 : 9'($urandom);
                        bv[k] = (s == 0) ? 7'd0 : 7'($urandom);
                    end
                    send();
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (sb_q.size() != 0 || (n_push - push0) != 40 || (n_pop - pop0) != 40) begin
            errors++;
            $display("FAIL random_count: pushed=%0d popped=%0d left=%0d required 40 40 0",
                     n_push - push0, n_pop - pop0, sb_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_inputs();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_bit();
        test_carry_only();
        test_all_ones();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ha_array_reducer.md
Name: ha_array_reducer

Overview:
- Consumer end of the 8x8 approximate-multiplier HA-array interface.
- Accepts one operand set of four half-adder-array rows (ha_array_k_t / ha_array_k_b) through a valid/ready handshake.
- Reduces the rows sequentially, one row per cycle, into a final unsigned product.
- Presents the product on a valid/ready output port; sits between the partial-product compression stage and downstream accumulation logic.

Parameters:
- ROWS, 4, number of HA-array rows per operand set; row k has base weight 2^(2k).
- TW, 9, width of each t (sum) vector; t[i] has weight 2^i within its row.
- BW, 7, width of each b (carry) vector; b[i] has weight 2^(i+2) within its row.
- PW, 17, product width; no saturation needed.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set this cycle.
- ha_array_0_b  input  7  row 0 carries.
- ha_array_0_t  input  9  row 0 sums.
- ha_array_1_b  input  7  row 1 carries.
- ha_array_1_t  input  9  row 1 sums.
- ha_array_2_b  input  7  row 2 carries.
- ha_array_2_t  input  9  row 2 sums.
- ha_array_3_b  input  7  row 3 carries.
- ha_array_3_t  input  9  row 3 sums.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts the product.
- p  output  PW  reduced product.
- busy  output  1  high in ACCUM.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, p=0, busy=0, row counter=0, accumulator=0, row capture registers=0.
- Row value, per row: row_k = sum(t[i]·2^i) + sum(b[i]·2^(i+2)). Each row value is at most 1019.
- Product: p = Σ row_k·2^(2k). The maximum is 86615, which fits in 17 bits. All arithmetic is unsigned and zero-extended to PW.
- Acceptance: on an edge where in_valid & in_ready, all eight input vectors are captured into registers. After that edge the inputs are don't-care.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1. On accept: go to ACCUM, cnt←0, acc←0.
  - ACCUM: in_ready=0, busy=1. Each edge: acc ← acc + (row_cnt << 2·cnt), cnt ← cnt+1. On the edge that adds row ROWS-1: p ← final sum, out_valid←1, go to DONE.
  - DONE: out_valid=1; p is held stable until out_valid & out_ready.
    - On handshake with no new accept: go to IDLE, out_valid←0.
    - p keeps its last value after the handshake (not cleared).
- Latency: out_valid rises exactly ROWS=4 edges after the accept edge. Throughput is one operand set per 5 cycles.
- Back-to-back: in DONE, in_ready = out_ready (combinational).
  - If out_ready & in_valid on the same edge, the product is consumed and the new set is captured on that edge.
  - The FSM then goes directly to ACCUM, cnt←0, acc←0, and out_valid←0.
  - No bubble through IDLE.
- Backpressure: with out_ready low, DONE is held indefinitely. in_ready stays 0 and no input is captured.
- in_valid is ignored while in ACCUM.
- Reset mid-operation: rst_n low at any point clears everything to reset values immediately (asynchronously). A partial product is discarded and never emitted.
- All-zero operand set: processed normally and produces p=0 with out_valid pulsed per handshake.

Test Plan:
1. Reset, then in_valid with row0 t=9'h001 and all else 0 -> accept at E0, out_valid high after E4, p=1, busy high for exactly 4 cycles.
2. Only b[6]=1 in every row, all t=0 -> p=256+1024+4096+16384=21760 (0x05500).
3. All t=9'h1FF and all b=7'h7F in every row -> p=86615 (0x15257); checks 17-bit width with no truncation.
4. Hold out_ready=0 for 10 cycles after out_valid -> p stable, in_ready=0, a new in_valid is not accepted; raise out_ready with in_valid=1 -> both handshakes occur on the same edge and the next result (row3 t[8]=1 only, p=16384) appears 4 edges later.
5. Assert rst_n=0 asynchronously during the 2nd ACCUM cycle -> out_valid=0, p=0, in_ready=1 immediately; no stale product is emitted after release.
6. Random operand stream with random out_ready -> every p equals the reference formula Σ row_k·2^(2k); no drops or duplicates; out_valid is never asserted in IDLE or ACCUM.
